// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: SPI-slave and fabric-requester signals of spi_reg_ctrl
interface spi_reg_ctrl_if;
  logic        spi_busy;
  logic [31:0] spi_rx_data;
  logic [31:0] spi_tx_data;
  logic        fab_req;
  logic        fab_we;
  logic [3:0]  fab_addr;
  logic [15:0] fab_wdata;
  logic        fab_gnt;
  logic [15:0] fab_rdata;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  err_cnt;
  modport master (
    output spi_busy, spi_rx_data, fab_req, fab_we, fab_addr, fab_wdata,
    input  spi_tx_data, fab_gnt, fab_rdata, frame_done, frame_err, err_cnt
  );
  modport slave (
    input  spi_busy, spi_rx_data, fab_req, fab_we, fab_addr, fab_wdata,
    output spi_tx_data, fab_gnt, fab_rdata, frame_done, frame_err, err_cnt
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI frame decoder and SPI-priority shared 16x16 register file; SPI_REG_PARITY_EN enables even-parity frame checking
module spi_reg_ctrl #(
  parameter logic [15:0] ID_VALUE = 16'hC0DE
) (
  input logic clk,
  input logic rst_n,
  spi_reg_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
  state_t state;
  logic busy_q, armed, c_we, par_bad, fab_go, gnt, done, err;
  logic [3:0] c_addr;
  logic [15:0] c_wdata, data, rdata;
  logic [7:0] status, err_cnt;
  logic [31:0] tx;
  logic [15:0] regs [16];
  logic rx_par;
`ifdef SPI_REG_PARITY_EN
  assign rx_par = ^bus.spi_rx_data;
`else
  logic unused_bits;
  assign unused_bits = ^{bus.spi_rx_data[30:28], bus.spi_rx_data[23:16]};
  assign rx_par = 1'b0;
`endif
  function automatic logic [15:0] rd(input logic [3:0] a);
    return a == 4'd0 ? ID_VALUE : regs[a];
  endfunction
  assign fab_go = bus.fab_req && !gnt && state != EXEC;
  assign bus.spi_tx_data = tx;
  assign bus.fab_gnt = gnt;
  assign bus.fab_rdata = rdata;
  assign bus.frame_done = done;
  assign bus.frame_err = err;
  assign bus.err_cnt = err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy_q <= 1'b1;
      armed <= 1'b0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
      par_bad <= 1'b0;
      status <= '0;
      data <= '0;
      tx <= '0;
      gnt <= 1'b0;
      rdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      busy_q <= bus.spi_busy;
      if (bus.spi_busy && !busy_q) armed <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      gnt <= fab_go;
      if (fab_go && bus.fab_we && bus.fab_addr != 4'd0) regs[bus.fab_addr] <= bus.fab_wdata;
      if (fab_go && !bus.fab_we) rdata <= rd(bus.fab_addr);
      unique case (state)
        IDLE:
          if (armed && busy_q && !bus.spi_busy) begin
            c_we <= bus.spi_rx_data[31];
            c_addr <= bus.spi_rx_data[27:24];
            c_wdata <= bus.spi_rx_data[15:0];
            par_bad <= rx_par;
            state <= DECODE;
          end
        DECODE: begin
          status <= par_bad ? 8'hE1 : (c_we && c_addr == 4'd0) ? 8'hE2 : 8'h5A;
          data <= '0;
          state <= (par_bad || (c_we && c_addr == 4'd0)) ? RESP : EXEC;
        end
        EXEC: begin
          if (c_we) regs[c_addr] <= c_wdata;
          data <= c_we ? c_wdata : rd(c_addr);
          state <= RESP;
        end
        RESP: begin
          tx <= {status, 4'h0, par_bad ? 4'h0 : c_addr, data};
          done <= status == 8'h5A;
          err <= status != 8'h5A;
          if (status != 8'h5A && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command decoder and register-file arbiter behind the 32-bit SPI slave. It sequences one register read or write per SPI frame: it latches the received word when the slave's busy drops, executes the command against a 16 x 16-bit register file, and loads the response word for the next frame. It also shares the register file with an FPGA-fabric requester, with SPI having priority.

## Interface
- `ID_VALUE`, default 16'hC0DE: read-only content of register 0.
- `clk` in 1: system clock, shared with the SPI slave.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_busy` in 1: slave `busy`; a falling edge means the frame is complete.
- `spi_rx_data` in 32: slave received word.
- `spi_tx_data` out 32: word the slave shifts out on the next frame.
- `fab_req` in 1: fabric access request; held until `fab_gnt`.
- `fab_we` in 1: fabric write (1) or read (0).
- `fab_addr` in 4: fabric register address.
- `fab_wdata` in 16: fabric write data.
- `fab_gnt` out 1: one-cycle pulse when the access is performed.
- `fab_rdata` out 16: read data, valid while `fab_gnt`=1; holds its value otherwise.
- `frame_done` out 1: one-cycle pulse per executed SPI command.
- `frame_err` out 1: one-cycle pulse per rejected SPI frame.
- `err_cnt` out 8: rejected-frame count, saturating at 255.

## Operation
- Command frame layout:
  - bit 31 = W (1 write, 0 read).
  - bits [27:24] = address.
  - bit 23 = parity (see Configuration).
  - bits [15:0] = write data.
  - bits [30:28] and [22:16] are ignored.
- Response word: {status[7:0], 4'h0, addr[3:0], data[15:0]}.
  - Status 8'h5A = OK.
  - Status 8'hE1 = parity error.
  - Status 8'hE2 = write to read-only register 0.
  - For a write, data is the new register value; for a read, the register contents; for an error, 16'h0000.
- Register 0 always reads `ID_VALUE`. Writes to it from SPI or fabric are dropped; SPI writes return status 8'hE2.
- State machine:
  - IDLE: wait for `spi_busy` falling edge (registered copy = 1, current = 0) while armed. Then latch `spi_rx_data` and go to DECODE.
  - DECODE: check parity/address. Go to EXEC if valid, otherwise to RESP with an error status.
  - EXEC: perform the register-file access (one cycle), then go to RESP.
  - RESP: load `spi_tx_data`, pulse `frame_done` or `frame_err`, return to IDLE.
- Arming: cleared by reset, set on the first `spi_busy` rising edge seen after reset. A busy falling edge while unarmed is ignored, so a frame that was already in progress at reset release is discarded.
- `spi_tx_data` changes only in RESP, which occurs while `spi_busy` is low, so it never changes mid-shift.
- Arbiter:
  - A fabric request is granted in any cycle where the FSM is not in EXEC and `fab_gnt` is currently 0.
  - The access is performed at the next edge, together with the `fab_gnt` pulse.
  - The requester drops `fab_req` the cycle after seeing `fab_gnt`, so the throughput limit is one fabric access per 2 cycles.
- A fabric write and an SPI write to the same register are serialized; the later write wins.
- A new busy falling edge arriving before the FSM returns to IDLE is not possible: a frame takes at least 32 SCK periods. This is not checked.

## Timing
- Reset values:
  - FSM = IDLE, armed = 0.
  - All registers = 0 (register 0 still reads `ID_VALUE`).
  - `spi_tx_data` = 32'h0000_0000.
  - `fab_gnt` = 0, `fab_rdata` = 0.
  - `frame_done` = 0, `frame_err` = 0, `err_cnt` = 0.
- Busy falling edge detected at edge N:
  - DECODE at N+1.
  - EXEC at N+2.
  - RESP at N+3: `spi_tx_data` valid and `frame_done` high from N+3 until N+4.
  - The error path is one cycle shorter: `frame_err` high from N+2 to N+3.
- Fabric access: `fab_req` sampled high at edge M with the arbiter free gives `fab_gnt`=1 and valid `fab_rdata` (or the write committed) at edge M+1. If the FSM is in EXEC at M, the grant slips one cycle.
- Asserting `rst_n` mid-frame or mid-access aborts immediately: no register write and no grant. The in-flight frame is then discarded per the arming rule.
- `err_cnt` increments in the same cycle as `frame_err` and holds at 255.

## Configuration
- `SPI_REG_PARITY_EN` defined:
  - bit 23 must make bits [31:0] even parity.
  - Mismatch gives status 8'hE1, `frame_err`, an `err_cnt` increment, and no register access.
- `SPI_REG_PARITY_EN` undefined: bit 23 is ignored, and status 8'hE1 and the parity path never occur.

## Test plan
- Reset then read register 0: frame 32'h0000_0000 (parity off) gives `spi_tx_data` = 32'h5A00_C0DE and one `frame_done` pulse.
- SPI write 16'h1234 to register 5, then SPI read of register 5: responses are 32'h5A05_1234 both times, and a fabric read of address 5 returns 16'h1234.
- With `SPI_REG_PARITY_EN` defined, send a frame with bad parity: response 32'hE100_0000 (address field 0), `frame_err` pulse, `err_cnt` = 1, target register unchanged. Send 256 bad frames: `err_cnt` stays at 255.
- SPI write to register 0: status 8'hE2, register 0 still reads 16'hC0DE.
- Fabric write to register 3 with `fab_req` held across an SPI EXEC cycle: the grant is delayed one cycle and there is only one `fab_gnt` pulse. The final value follows write order.
- Assert `rst_n` low while `spi_busy`=1, release it, then let busy fall: no `frame_done`, `spi_tx_data` stays 32'h0. The next complete frame is processed normally.
